wb_pipe: RTL and testbench
==========================

# wb_pipe

Parametrised write-back stage with an input pipeline register, a load-wait state machine, and load-data alignment/extension. Sits between the MEM stage and the register file. Accepts one instruction per cycle under a valid/ready handshake and stalls MEM while a data-cache load response is outstanding. Drives a registered RF write port plus forwarding and pending-load hazard outputs.

## Interface
Parameters:
- DATA_W, 32, datapath width; power of two, ≥32.
- REG_AW, 5, register address width.
- OFF_W, log2(DATA_W/8), byte-offset width; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pdata  in  DATA_W  EXE/MEM result.
- in_rd  in  REG_AW  destination register.
- in_needs_wb  in  1  instruction writes RF.
- in_is_load  in  1  result comes from the data cache.
- in_ld_size  in  2  0 byte, 1 half, 2 word, 3 dword.
- in_ld_unsigned  in  1  zero-extend instead of sign-extend.
- in_byte_off  in  OFF_W  address low bits of the load.
- rdata_valid  in  1  data-cache response valid.
- rdata  in  DATA_W  data-cache response.
- rf_wen, rf_waddr, rf_wdata  out  1/REG_AW/DATA_W  registered RF write port.
- pend_ld_valid, pend_ld_rd  out  1/REG_AW  load waiting for data.
- err_unexp_rdata  out  1  sticky: rdata_valid seen with no load pending.

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE and WAIT_LD.
- in_ready = !rst && (state==IDLE || (state==WAIT_LD && rdata_valid)).
- Accept = in_valid && in_ready. The fields are captured.
- Non-load accept: the next cycle drives rf_wen = needs_wb && rd≠0, rf_waddr = rd, rf_wdata = pdata.
- Load accept: go to WAIT_LD and hold the captured rd, size, unsigned and offset. While waiting:
  - rf_wen = 0.
  - pend_ld_valid = 1.
  - pend_ld_rd = held rd.
- WAIT_LD with rdata_valid: the aligned value is registered to rf_* (rf_wen = needs_wb && rd≠0). A simultaneous accept is legal: a new load stays in WAIT_LD, and a non-load returns to IDLE. Its write appears one cycle after the load's write.
- Alignment: width w = 8<<size, clipped to DATA_W. Lane = byte_off >> size. Field = rdata[w*lane +: w].
  - Upper bits are sign-extended from the field MSB unless unsigned.
  - Low offset bits beyond alignment are ignored.
  - w == DATA_W passes rdata through.
- A write to rd=0 is never issued. Data is still computed.
- rdata_valid in IDLE is ignored for the RF and sets err_unexp_rdata. The flag clears only on rst.
- Reset in WAIT_LD drops the pending load: no write, and a later rdata_valid sets err.

## Timing
- Reset values:
  - state IDLE.
  - rf_wen 0, rf_waddr 0, rf_wdata 0.
  - pend_ld_valid 0, pend_ld_rd 0.
  - err_unexp_rdata 0.
  - in_ready 0 while rst is high, 1 on the first cycle after.
- ALU latency: accept edge to rf_wen high is 1 cycle. Throughput is 1 per cycle.
- Load latency: the rdata_valid edge to rf_wen high is 1 cycle. rdata is never consumed in the acceptance cycle itself.
- pend_ld_* goes high in the cycle after load accept. It drops in the cycle rf_wen for that load rises.
- rf_* outputs are registered. Every rf_wen pulse lasts exactly one cycle per instruction.
- Upstream must hold inputs stable while in_valid && !in_ready.

## Structure
- Package wb_pkg holds:
  - enum ld_size_e {LD_B, LD_H, LD_W, LD_D}.
  - enum wb_state_e {WB_IDLE, WB_WAIT_LD}.
  - constant REG_ZERO = 0.
- Sub-module load_align (combinational; params DATA_W): inputs rdata, size, unsigned, byte_off. Output is the extended data.
- Top holds the FSM, capture registers, RF output registers and the error flag.

## Test plan
- ALU back-to-back, DATA_W=32: rd=3 with 0x11 and rd=4 with 0x22 on consecutive cycles → rf writes (3,0x11) then (4,0x22) on consecutive cycles. in_ready stays 1.
- Signed byte load, off=2: rdata=0x12AB3456 arrives 3 cycles after accept → in_ready=0 and pend_ld_rd=5 for 3 cycles. Then rf_wdata=0xFFFFFFAB; the unsigned variant gives 0x000000AB.
- Half load, off=3, signed: rdata=0x8001_7FFF → 0xFFFF8001, because off[0] is ignored. Word load, off=1 → 0x80017FFF.
- Load response with a simultaneous ALU accept: rdata_valid plus an accept of rd=7/0x99 → load write, then (7,0x99) the next cycle, then IDLE.
- rd=0: load or ALU result targeting x0 → rf_wen never asserts. pend_ld_valid still behaves normally.
- Reset in WAIT_LD, then rdata_valid: rst for 1 cycle → no rf write, err_unexp_rdata=1 after the response, 0 after the next rst. A DATA_W=64 dword load with off=0 passes 64 bits through unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back stage
package wb_pkg;
    typedef enum logic [1:0] {LD_B, LD_H, LD_W, LD_D} ld_size_e;
    typedef enum logic {WB_IDLE, WB_WAIT_LD} wb_state_e;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/wb_pipe_if.sv
// wb_pipe_if: MEM-side handshake, cache response and RF write/hazard signals of the write-back stage
interface wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pdata;
    logic [REG_AW-1:0] in_rd;
    logic              in_needs_wb;
    logic              in_is_load;
    logic [1:0]        in_ld_size;
    logic              in_ld_unsigned;
    logic [OFF_W-1:0]  in_byte_off;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              pend_ld_valid;
    logic [REG_AW-1:0] pend_ld_rd;
    logic              err_unexp_rdata;
    modport master (
        output in_valid, in_pdata, in_rd, in_needs_wb, in_is_load, in_ld_size,
               in_ld_unsigned, in_byte_off, rdata_valid, rdata,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, pend_ld_valid, pend_ld_rd,
               err_unexp_rdata
    );
    modport slave (
        input  in_valid, in_pdata, in_rd, in_needs_wb, in_is_load, in_ld_size,
               in_ld_unsigned, in_byte_off, rdata_valid, rdata,
        output in_ready, rf_wen, rf_waddr, rf_wdata, pend_ld_valid, pend_ld_rd,
               err_unexp_rdata
    );
endinterface

// File: rtl/load_align.sv
// load_align: selects the naturally aligned load field from a cache word and sign/zero-extends it
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]               rdata,
    input  ld_size_e                        size,
    input  logic                            is_unsigned,
    input  logic [$clog2(DATA_W / 8)-1:0]   byte_off,
    output logic [DATA_W-1:0]               data_out
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    logic [OFF_W-1:0]  base;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] mask;
    logic              sign;
    // Field widths at or beyond DATA_W shift the mask fully out, giving a pass-through.
    always_comb begin
        base     = (byte_off >> size) << size;
        sh       = rdata >> {base, 3'b000};
        mask     = ~({DATA_W{1'b1}} << (8 << size));
        sign     = |(sh & mask & ~(mask >> 1));
        data_out = (sh & mask) | ((sign && !is_unsigned) ? ~mask : '0);
    end
endmodule

// File: rtl/wb_pipe.sv
// wb_pipe: write-back stage with load-wait FSM, load alignment and registered RF write port
module wb_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic      clk,
    input logic      rst,
    wb_pipe_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    wb_state_e         state, state_nx;
    logic [REG_AW-1:0] ld_rd, alu_rd;
    ld_size_e          ld_size;
    logic              ld_uns, ld_wb;
    logic [OFF_W-1:0]  ld_off;
    logic [DATA_W-1:0] ld_data, alu_data;
    logic              alu_v, alu_wb;
    logic              accept, ld_done, alu_in;

    assign bus.in_ready      = !rst && (state == WB_IDLE || bus.rdata_valid);
    assign accept            = bus.in_valid && bus.in_ready;
    assign ld_done           = state == WB_WAIT_LD && bus.rdata_valid;
    assign alu_in            = accept && !bus.in_is_load;
    assign bus.pend_ld_valid = state == WB_WAIT_LD;
    assign bus.pend_ld_rd    = ld_rd;

    always_comb begin
        state_nx = accept ? (bus.in_is_load ? WB_WAIT_LD : WB_IDLE) : (ld_done ? WB_IDLE : state);
    end

    load_align #(.DATA_W(DATA_W)) u_align (
        .rdata      (bus.rdata),
        .size       (ld_size),
        .is_unsigned(ld_uns),
        .byte_off   (ld_off),
        .data_out   (ld_data)
    );

    // An ALU op accepted alongside a load response is parked one cycle in alu_*,
    // and keeps being parked while back-to-back ALU ops follow it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= WB_IDLE;
            ld_rd               <= '0;
            ld_size             <= LD_B;
            ld_uns              <= 1'b0;
            ld_off              <= '0;
            ld_wb               <= 1'b0;
            alu_v               <= 1'b0;
            alu_rd              <= '0;
            alu_data            <= '0;
            alu_wb              <= 1'b0;
            bus.rf_wen          <= 1'b0;
            bus.rf_waddr        <= '0;
            bus.rf_wdata        <= '0;
            bus.err_unexp_rdata <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept && bus.in_is_load) begin
                ld_rd   <= bus.in_rd;
                ld_size <= ld_size_e'(bus.in_ld_size);
                ld_uns  <= bus.in_ld_unsigned;
                ld_off  <= bus.in_byte_off;
                ld_wb   <= bus.in_needs_wb;
            end
            alu_v <= alu_in && (ld_done || alu_v);
            if (alu_in) begin
                alu_rd   <= bus.in_rd;
                alu_data <= bus.in_pdata;
                alu_wb   <= bus.in_needs_wb;
            end
            if (ld_done) begin
                bus.rf_wen   <= ld_wb && ld_rd != REG_AW'(REG_ZERO);
                bus.rf_waddr <= ld_rd;
                bus.rf_wdata <= ld_data;
            end else if (alu_v) begin
                bus.rf_wen   <= alu_wb && alu_rd != REG_AW'(REG_ZERO);
                bus.rf_waddr <= alu_rd;
                bus.rf_wdata <= alu_data;
            end else begin
                bus.rf_wen   <= alu_in && bus.in_needs_wb && bus.in_rd != REG_AW'(REG_ZERO);
                bus.rf_waddr <= bus.in_rd;
                bus.rf_wdata <= bus.in_pdata;
            end
            if (bus.rdata_valid && state == WB_IDLE) bus.err_unexp_rdata <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_pipe.sv
// tb_wb_pipe: directed scoreboard bench for wb_pipe at DATA_W=32 and DATA_W=64
module tb_wb_pipe;
    import wb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    typedef struct {
        int          at;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    wb_pipe_if #(.DATA_W(32), .REG_AW(5)) m();
    wb_pipe_if #(.DATA_W(64), .REG_AW(5)) m64();

    wb_pipe #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(m));
    wb_pipe #(.DATA_W(64), .REG_AW(5)) dut64 (.clk(clk), .rst(rst), .bus(m64));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m.rf_wen === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", {59'd0, m.rf_waddr}, 64'hFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_cycle", 64'(cyc), 64'(e.at));
                chk("write_addr", {59'd0, m.rf_waddr}, {59'd0, e.addr});
                chk("write_data", {32'd0, m.rf_wdata}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input int dly, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.at = cyc + dly;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d, input bit wb, input int dly);
        m.in_valid = 1'b1;
        m.in_is_load = 1'b0;
        m.in_rd = rd;
        m.in_pdata = d;
        m.in_needs_wb = wb;
        if (wb && rd != 5'd0) push(dly, rd, d);
    endtask

    task automatic ld(input logic [4:0] rd, input logic [1:0] sz, input bit un, input logic [1:0] off);
        m.in_valid = 1'b1;
        m.in_is_load = 1'b1;
        m.in_rd = rd;
        m.in_pdata = 32'hCAFE_0000;
        m.in_needs_wb = 1'b1;
        m.in_ld_size = sz;
        m.in_ld_unsigned = un;
        m.in_byte_off = off;
    endtask

    task automatic load_seq(input logic [4:0] rd, input logic [1:0] sz, input bit un,
                            input logic [1:0] off, input logic [31:0] rdat,
                            input logic [31:0] exp, input int waits);
        ld(rd, sz, un, off);
        tick();
        m.in_valid = 1'b0;
        for (int i = 0; i < waits; i++) begin
            #1;
            chk("wait_ready", {63'd0, m.in_ready}, 64'd0);
            chk("wait_pend_valid", {63'd0, m.pend_ld_valid}, 64'd1);
            chk("wait_pend_rd", {59'd0, m.pend_ld_rd}, {59'd0, rd});
            tick();
        end
        m.rdata_valid = 1'b1;
        m.rdata = rdat;
        if (rd != 5'd0) push(1, rd, exp);
        #1;
        chk("resp_ready", {63'd0, m.in_ready}, 64'd1);
        tick();
        m.rdata_valid = 1'b0;
        #1;
        chk("pend_drop", {63'd0, m.pend_ld_valid}, 64'd0);
    endtask

    task automatic ld64(input logic [4:0] rd, input logic [1:0] sz, input bit un,
                        input logic [2:0] off, input logic [63:0] rdat, input logic [63:0] exp);
        m64.in_valid = 1'b1;
        m64.in_is_load = 1'b1;
        m64.in_rd = rd;
        m64.in_needs_wb = 1'b1;
        m64.in_ld_size = sz;
        m64.in_ld_unsigned = un;
        m64.in_byte_off = off;
        tick();
        m64.in_valid = 1'b0;
        m64.rdata_valid = 1'b1;
        m64.rdata = rdat;
        #1;
        chk("d64_pend", {63'd0, m64.pend_ld_valid}, 64'd1);
        tick();
        m64.rdata_valid = 1'b0;
        #1;
        chk("d64_wen", {63'd0, m64.rf_wen}, 64'd1);
        chk("d64_waddr", {59'd0, m64.rf_waddr}, {59'd0, rd});
        chk("d64_wdata", m64.rf_wdata, exp);
        tick();
    endtask

    initial begin
        m.in_valid = 0; m.in_pdata = 0; m.in_rd = 0; m.in_needs_wb = 0; m.in_is_load = 0;
        m.in_ld_size = 0; m.in_ld_unsigned = 0; m.in_byte_off = 0; m.rdata_valid = 0; m.rdata = 0;
        m64.in_valid = 0; m64.in_pdata = 0; m64.in_rd = 0; m64.in_needs_wb = 0; m64.in_is_load = 0;
        m64.in_ld_size = 0; m64.in_ld_unsigned = 0; m64.in_byte_off = 0; m64.rdata_valid = 0; m64.rdata = 0;
        tick();
        tick();
        chk("rst_ready", {63'd0, m.in_ready}, 64'd0);
        chk("rst_wen", {63'd0, m.rf_wen}, 64'd0);
        chk("rst_waddr", {59'd0, m.rf_waddr}, 64'd0);
        chk("rst_wdata", {32'd0, m.rf_wdata}, 64'd0);
        chk("rst_pend", {58'd0, m.pend_ld_valid, m.pend_ld_rd}, 64'd0);
        chk("rst_err", {63'd0, m.err_unexp_rdata}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, m.in_ready}, 64'd1);
        tick();
        alu(5'd3, 32'h11, 1'b1, 1);
        #1 chk("alu_ready0", {63'd0, m.in_ready}, 64'd1);
        tick();
        alu(5'd4, 32'h22, 1'b1, 1);
        #1 chk("alu_ready1", {63'd0, m.in_ready}, 64'd1);
        tick();
        m.in_valid = 1'b0;
        tick();
        #1 chk("alu_drain", 64'(sb.size()), 64'd0);
        load_seq(5'd5, LD_B, 1'b0, 2'd2, 32'h12AB_3456, 32'hFFFF_FFAB, 3);
        load_seq(5'd5, LD_B, 1'b1, 2'd2, 32'h12AB_3456, 32'h0000_00AB, 3);
        load_seq(5'd6, LD_B, 1'b0, 2'd1, 32'h12AB_3456, 32'h0000_0034, 1);
        load_seq(5'd8, LD_H, 1'b0, 2'd3, 32'h8001_7FFF, 32'hFFFF_8001, 2);
        load_seq(5'd9, LD_H, 1'b1, 2'd2, 32'h8001_7FFF, 32'h0000_8001, 0);
        load_seq(5'd10, LD_W, 1'b0, 2'd1, 32'h8001_7FFF, 32'h8001_7FFF, 1);
        load_seq(5'd11, LD_D, 1'b0, 2'd0, 32'hF00D_1234, 32'hF00D_1234, 1);
        tick();
        #1 chk("load_drain", 64'(sb.size()), 64'd0);
        ld(5'd6, LD_B, 1'b0, 2'd0);
        tick();
        m.in_valid = 1'b0;
        tick();
        m.rdata_valid = 1'b1;
        m.rdata = 32'h0000_00F0;
        push(1, 5'd6, 32'hFFFF_FFF0);
        alu(5'd7, 32'h99, 1'b1, 2);
        #1 chk("sim_ready", {63'd0, m.in_ready}, 64'd1);
        tick();
        m.in_valid = 1'b0;
        m.rdata_valid = 1'b0;
        #1 chk("sim_pend", {63'd0, m.pend_ld_valid}, 64'd0);
        tick();
        #1 chk("sim_idle_ready", {63'd0, m.in_ready}, 64'd1);
        chk("sim_drain", 64'(sb.size()), 64'd0);
        ld(5'd12, LD_H, 1'b1, 2'd2);
        tick();
        m.in_valid = 1'b0;
        tick();
        m.rdata_valid = 1'b1;
        m.rdata = 32'hBEEF_1234;
        push(1, 5'd12, 32'h0000_BEEF);
        ld(5'd13, LD_B, 1'b0, 2'd1);
        tick();
        m.in_valid = 1'b0;
        m.rdata_valid = 1'b0;
        #1 chk("ldld_pend", {63'd0, m.pend_ld_valid}, 64'd1);
        chk("ldld_pend_rd", {59'd0, m.pend_ld_rd}, 64'd13);
        tick();
        m.rdata_valid = 1'b1;
        m.rdata = 32'h0000_8000;
        push(1, 5'd13, 32'hFFFF_FF80);
        tick();
        m.rdata_valid = 1'b0;
        #1 chk("ldld_drain", 64'(sb.size()), 64'd0);
        load_seq(5'd0, LD_W, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h0, 2);
        #1 chk("x0_load_wen", {63'd0, m.rf_wen}, 64'd0);
        tick();
        alu(5'd0, 32'h55, 1'b1, 1);
        tick();
        m.in_valid = 1'b0;
        #1 chk("x0_alu_wen", {63'd0, m.rf_wen}, 64'd0);
        tick();
        alu(5'd9, 32'h66, 1'b0, 1);
        tick();
        m.in_valid = 1'b0;
        #1 chk("nowb_wen", {63'd0, m.rf_wen}, 64'd0);
        chk("no_err_yet", {63'd0, m.err_unexp_rdata}, 64'd0);
        tick();
        ld(5'd14, LD_W, 1'b0, 2'd0);
        tick();
        m.in_valid = 1'b0;
        #1 chk("rw_pend", {63'd0, m.pend_ld_valid}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("rw_pend_drop", {63'd0, m.pend_ld_valid}, 64'd0);
        chk("rw_ready", {63'd0, m.in_ready}, 64'd1);
        chk("rw_err0", {63'd0, m.err_unexp_rdata}, 64'd0);
        m.rdata_valid = 1'b1;
        m.rdata = 32'h1234_5678;
        tick();
        m.rdata_valid = 1'b0;
        #1 chk("rw_err1", {63'd0, m.err_unexp_rdata}, 64'd1);
        chk("rw_no_write", {63'd0, m.rf_wen}, 64'd0);
        tick();
        #1 chk("err_sticky", {63'd0, m.err_unexp_rdata}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("err_cleared", {63'd0, m.err_unexp_rdata}, 64'd0);
        tick();
        ld64(5'd10, LD_D, 1'b0, 3'd0, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
        ld64(5'd11, LD_W, 1'b0, 3'd4, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_89AB_CDEF);
        ld64(5'd12, LD_H, 1'b1, 3'd7, 64'hF00D_0000_0000_0000, 64'h0000_0000_0000_F00D);
        tick();
        #1 chk("final_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
